// File: rtl/change_dispense_controller.sv
// ---------------------------------------------------------------------------
// change_dispense_controller
//
// Sequences the coin hopper that returns change. A single start pulse hands
// over the amount owed; the block then ejects one coin at a time (largest
// denomination that fits and is in stock), waits for the drop sensor to
// confirm each coin, and keeps the per-denomination inventory up to date.
// Completion, jams (no drop confirmation) and short change (no coin fits)
// are reported.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, change_amount     change request (sampled in IDLE only)
//   load_inv, inv_*_in       inventory refill (IDLE or FAULT only)
//   clear                    leave FAULT
//   hopper_ack               coin-dropped sensor
//   eject[2:0]               one-hot solenoid drive {hi,mid,lo}
//   busy, done, error        status
//   err_code[1:0]            00 none, 01 short, 10 jam
//   remaining                amount still owed
//   inv_hi/inv_mid/inv_lo    current inventory counts
// ---------------------------------------------------------------------------
module change_dispense_controller #(
    parameter int AMT_W       = 10,
    parameter int CNT_W       = 8,
    parameter int DEN_HI      = 20,
    parameter int DEN_MID     = 10,
    parameter int DEN_LO      = 5,
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amount,
    input  logic             load_inv,
    input  logic [CNT_W-1:0] inv_hi_in,
    input  logic [CNT_W-1:0] inv_mid_in,
    input  logic [CNT_W-1:0] inv_lo_in,
    input  logic             clear,
    input  logic             hopper_ack,
    output logic [2:0]       eject,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] inv_hi,
    output logic [CNT_W-1:0] inv_mid,
    output logic [CNT_W-1:0] inv_lo
);

    localparam logic [AMT_W-1:0] L_HI  = AMT_W'(DEN_HI);
    localparam logic [AMT_W-1:0] L_MID = AMT_W'(DEN_MID);
    localparam logic [AMT_W-1:0] L_LO  = AMT_W'(DEN_LO);

    localparam int PW = $clog2(PULSE_CYC + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [PW-1:0] L_PLAST = PW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] L_TLAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [2:0] SEL_HI  = 3'b100;
    localparam logic [2:0] SEL_MID = 3'b010;
    localparam logic [2:0] SEL_LO  = 3'b001;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_JAM   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_ACK,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic [2:0]       r_eject;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [1:0]       r_err_code;
    logic [AMT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_inv_hi;
    logic [CNT_W-1:0] r_inv_mid;
    logic [CNT_W-1:0] r_inv_lo;
    logic [2:0]       r_sel;
    logic [PW-1:0]    r_pcnt;
    logic [TW-1:0]    r_tcnt;
    logic             r_pend;
    logic             r_ack_d;

    logic [2:0]       w_sel;
    logic [AMT_W-1:0] w_den;
    logic             w_ack_rise;
    logic             w_ack_now;

    // Largest denomination that fits the amount owed and is in stock.
    always_comb begin
        w_sel = 3'b000;
        if ((L_HI <= r_remaining) && (r_inv_hi != '0)) begin
            w_sel = SEL_HI;
        end else if ((L_MID <= r_remaining) && (r_inv_mid != '0)) begin
            w_sel = SEL_MID;
        end else if ((L_LO <= r_remaining) && (r_inv_lo != '0)) begin
            w_sel = SEL_LO;
        end
    end

    always_comb begin
        w_den = '0;
        case (r_sel)
            SEL_HI:  w_den = L_HI;
            SEL_MID: w_den = L_MID;
            SEL_LO:  w_den = L_LO;
            default: w_den = '0;
        endcase
    end

    // Only a rising edge of the sensor counts as a new coin, so an ack held
    // high across the next pass cannot credit a second coin.
    assign w_ack_rise = hopper_ack & ~r_ack_d;
    assign w_ack_now  = w_ack_rise | r_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_eject     <= 3'b000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_remaining <= '0;
            r_inv_hi    <= '0;
            r_inv_mid   <= '0;
            r_inv_lo    <= '0;
            r_sel       <= 3'b000;
            r_pcnt      <= '0;
            r_tcnt      <= '0;
            r_pend      <= 1'b0;
            r_ack_d     <= 1'b0;
        end else begin
            r_ack_d <= hopper_ack;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_inv) begin
                        r_inv_hi  <= inv_hi_in;
                        r_inv_mid <= inv_mid_in;
                        r_inv_lo  <= inv_lo_in;
                    end
                    if (start) begin
                        r_remaining <= change_amount;
                        r_busy      <= 1'b1;
                        r_state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (r_remaining == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_sel != 3'b000) begin
                        r_sel   <= w_sel;
                        r_eject <= w_sel;
                        r_pcnt  <= '0;
                        r_pend  <= 1'b0;
                        r_state <= S_EJECT;
                    end else begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_SHORT;
                        r_state    <= S_FAULT;
                    end
                end
                S_EJECT: begin
                    // A coin can drop before the pulse ends; remember it.
                    if (w_ack_rise) begin
                        r_pend <= 1'b1;
                    end
                    if (r_pcnt == L_PLAST) begin
                        r_eject <= 3'b000;
                        r_tcnt  <= '0;
                        r_state <= S_WAIT_ACK;
                    end else begin
                        r_pcnt <= r_pcnt + PW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (w_ack_now) begin
                        r_remaining <= r_remaining - w_den;
                        case (r_sel)
                            SEL_HI:  if (r_inv_hi  != '0) r_inv_hi  <= r_inv_hi  - CNT_W'(1);
                            SEL_MID: if (r_inv_mid != '0) r_inv_mid <= r_inv_mid - CNT_W'(1);
                            SEL_LO:  if (r_inv_lo  != '0) r_inv_lo  <= r_inv_lo  - CNT_W'(1);
                            default: ;
                        endcase
                        r_pend  <= 1'b0;
                        r_state <= S_SELECT;
                    end else if (r_tcnt == L_TLAST) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_JAM;
                        r_state    <= S_FAULT;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    if (load_inv) begin
                        r_inv_hi  <= inv_hi_in;
                        r_inv_mid <= inv_mid_in;
                        r_inv_lo  <= inv_lo_in;
                    end
                    if (clear) begin
                        r_error     <= 1'b0;
                        r_err_code  <= ERR_NONE;
                        r_remaining <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_eject <= 3'b000;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign eject     = r_eject;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign err_code  = r_err_code;
    assign remaining = r_remaining;
    assign inv_hi    = r_inv_hi;
    assign inv_mid   = r_inv_mid;
    assign inv_lo    = r_inv_lo;

endmodule

// File: tb/tb_change_dispense_controller.sv
// ---------------------------------------------------------------------------
// Testbench for change_dispense_controller. Expected eject codes are queued
// when a request is issued and popped by a monitor as each pulse appears.
// ---------------------------------------------------------------------------
module tb_change_dispense_controller;

    localparam int AMT_W       = 10;
    localparam int CNT_W       = 8;
    localparam int PULSE_CYC   = 4;
    localparam int ACK_TIMEOUT = 1000;

    logic             clk;
    logic             rst;
    logic             start;
    logic [AMT_W-1:0] change_amount;
    logic             load_inv;
    logic [CNT_W-1:0] inv_hi_in;
    logic [CNT_W-1:0] inv_mid_in;
    logic [CNT_W-1:0] inv_lo_in;
    logic             clear;
    logic             hopper_ack;
    logic             ack_auto;
    logic             ack_man;
    logic [2:0]       eject;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] inv_hi;
    logic [CNT_W-1:0] inv_mid;
    logic [CNT_W-1:0] inv_lo;

    int         total = 0;
    int         bad   = 0;
    int         ack_mode = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_prev;
    int         mon_width;
    int         mon_cd;
    int         n;

    assign hopper_ack = ack_auto | ack_man;

    change_dispense_controller #(
        .AMT_W      (AMT_W),
        .CNT_W      (CNT_W),
        .DEN_HI     (20),
        .DEN_MID    (10),
        .DEN_LO     (5),
        .PULSE_CYC  (PULSE_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .change_amount(change_amount),
        .load_inv     (load_inv),
        .inv_hi_in    (inv_hi_in),
        .inv_mid_in   (inv_mid_in),
        .inv_lo_in    (inv_lo_in),
        .clear        (clear),
        .hopper_ack   (hopper_ack),
        .eject        (eject),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .remaining    (remaining),
        .inv_hi       (inv_hi),
        .inv_mid      (inv_mid),
        .inv_lo       (inv_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input int h, input int m, input int l);
        inv_hi_in  = CNT_W'(h);
        inv_mid_in = CNT_W'(m);
        inv_lo_in  = CNT_W'(l);
        load_inv   = 1'b1;
        cyc();
        load_inv   = 1'b0;
    endtask

    task automatic do_start(input int amt);
        change_amount = AMT_W'(amt);
        start         = 1'b1;
        cyc();
        start         = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    // which: 0 = done, 1 = error. Bounded wait; a timeout shows as a failed check.
    task automatic wait_sig(input string tag, input int which, input int max, output int cnt);
        cnt = 0;
        while (((which == 0) ? done : error) !== 1'b1 && cnt < max) begin
            cyc();
            cnt++;
        end
        check(tag, (which == 0) ? done : error, 1);
    endtask

    // Monitor: pops expected coin per new pulse, checks pulse width, and
    // optionally answers each pulse with an ack two cycles after it ends.
    initial begin
        ack_auto  = 1'b0;
        mon_prev  = 3'b000;
        mon_width = 0;
        mon_cd    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev  = 3'b000;
                mon_width = 0;
                mon_cd    = 0;
                ack_auto  = 1'b0;
            end else begin
                ack_auto = 1'b0;
                if (mon_cd != 0) begin
                    mon_cd--;
                    if (mon_cd == 0) ack_auto = 1'b1;
                end
                if (eject != 3'b000) begin
                    if (mon_prev == 3'b000) begin
                        if (exp_q.size() == 0) check("eject_unexpected", eject, 3'b000);
                        else check("eject_code", eject, exp_q.pop_front());
                        mon_width = 0;
                    end
                    mon_width++;
                end else if (mon_prev != 3'b000) begin
                    check("eject_width", mon_width, PULSE_CYC);
                    if (ack_mode == 1) mon_cd = 2;
                end
                mon_prev = eject;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; load_inv = 1'b0; clear = 1'b0; ack_man = 1'b0;
        change_amount = '0; inv_hi_in = '0; inv_mid_in = '0; inv_lo_in = '0;
        repeat (3) cyc();
        check("rst_eject", eject, 3'b000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_errcode", err_code, 0);
        check("rst_remaining", remaining, 0);
        check("rst_inv", {inv_hi, inv_mid, inv_lo}, 0);
        #2 rst = 1'b0;
        cyc();

        // Normal path: 35 = 20 + 10 + 5
        load(5, 5, 5);
        ack_mode = 1;
        exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
        do_start(35);
        wait_sig("normal_done", 0, 300, n);
        check("normal_remaining", remaining, 0);
        check("normal_inv_hi", inv_hi, 4);
        check("normal_inv_mid", inv_mid, 4);
        check("normal_inv_lo", inv_lo, 4);
        check("normal_error", error, 0);
        check("normal_queue_empty", exp_q.size(), 0);
        cyc();
        check("normal_done_once", done, 0);
        check("normal_busy_idle", busy, 0);

        // Substitution: one hi then mid, mid
        load(1, 5, 5);
        exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b010);
        do_start(40);
        wait_sig("subst_done", 0, 300, n);
        check("subst_inv", {inv_hi, inv_mid, inv_lo}, {8'd0, 8'd3, 8'd5});
        check("subst_queue_empty", exp_q.size(), 0);
        cyc();

        // Short change: one lo coin then nothing fits 10
        load(0, 0, 1);
        exp_q.push_back(3'b001);
        do_start(15);
        wait_sig("short_error", 1, 300, n);
        check("short_errcode", err_code, 2'b01);
        check("short_remaining", remaining, 10);
        check("short_busy", busy, 1);
        check("short_inv_lo", inv_lo, 0);
        do_start(5);
        check("fault_start_ignored", remaining, 10);
        check("fault_error_held", error, 1);
        do_clear();
        check("short_clear_error", error, 0);
        check("short_clear_code", err_code, 0);
        check("short_clear_busy", busy, 0);
        check("short_clear_remaining", remaining, 0);

        // Jam: no ack; error rises PULSE_CYC+ACK_TIMEOUT+2 cycles after start
        ack_mode = 0;
        load(5, 5, 5);
        exp_q.push_back(3'b010);
        do_start(10);                       // now in cycle T+1
        check("lat_T1_eject", eject, 3'b000);
        check("lat_T1_busy", busy, 1);
        cyc();                              // T+2
        check("lat_T2_eject", eject, 3'b010);
        repeat (PULSE_CYC + ACK_TIMEOUT - 1) cyc();
        check("jam_error_early", error, 0);
        cyc();
        check("jam_error_rise", error, 1);
        check("jam_errcode", err_code, 2'b10);
        check("jam_inv_mid", inv_mid, 5);
        check("jam_remaining", remaining, 10);
        check("jam_eject_off", eject, 3'b000);
        load(3, 3, 3);
        check("fault_load_inv", {inv_hi, inv_mid, inv_lo}, {8'd3, 8'd3, 8'd3});
        do_clear();
        check("jam_clear_error", error, 0);

        // Zero amount: done at T+2, no eject
        do_start(0);
        check("zero_T1_done", done, 0);
        cyc();
        check("zero_T2_done", done, 1);
        cyc();
        check("zero_T3_done", done, 0);
        check("zero_busy", busy, 0);

        // Start while busy is ignored
        load(5, 5, 5);
        ack_mode = 1;
        exp_q.push_back(3'b010);
        do_start(10);
        cyc(); cyc();
        do_start(20);
        wait_sig("busy_done", 0, 100, n);
        check("busy_inv_hi", inv_hi, 5);
        check("busy_inv_mid", inv_mid, 4);
        check("busy_remaining", remaining, 0);
        repeat (3) cyc();
        check("busy_idle", busy, 0);
        check("busy_queue_empty", exp_q.size(), 0);

        // Ack during EJECT pulse: credited once, WAIT_ACK finishes at once
        ack_mode = 0;
        load(0, 0, 5);
        exp_q.push_back(3'b001);
        do_start(5);                        // T+1
        cyc(); cyc();                       // T+3
        ack_man = 1'b1;
        cyc();                              // T+4
        ack_man = 1'b0;
        wait_sig("ackej_done", 0, 20, n);
        check("ackej_latency", n, 4);
        check("ackej_inv_lo", inv_lo, 4);
        check("ackej_remaining", remaining, 0);
        cyc();

        // Ack held 5 cycles credits one coin only
        load(0, 0, 5);
        exp_q.push_back(3'b001); exp_q.push_back(3'b001);
        do_start(10);                       // T+1
        repeat (PULSE_CYC + 1) cyc();       // first WAIT_ACK cycle
        ack_man = 1'b1;
        repeat (5) cyc();
        ack_man = 1'b0;
        cyc(); cyc();
        check("held_remaining", remaining, 5);
        check("held_inv_lo", inv_lo, 4);
        check("held_no_done", busy, 1);
        ack_man = 1'b1;
        cyc();
        ack_man = 1'b0;
        wait_sig("held_done", 0, 20, n);
        check("held_final_inv_lo", inv_lo, 3);
        check("held_final_remaining", remaining, 0);
        cyc();

        // Reset mid-EJECT: eject drops before any clock edge
        load(5, 5, 5);
        exp_q.push_back(3'b100);
        do_start(20);                       // T+1
        cyc(); cyc();                       // T+3, pulse in progress
        check("pre_rst_eject", eject, 3'b100);
        #2 rst = 1'b1;
        #1;
        check("async_rst_eject", eject, 3'b000);
        check("async_rst_busy", busy, 0);
        check("async_rst_remaining", remaining, 0);
        cyc();
        check("rst2_inv", {inv_hi, inv_mid, inv_lo}, 0);
        check("rst2_error", error, 0);
        check("rst2_queue_empty", exp_q.size(), 0);
        #2 rst = 1'b0;
        cyc();
        load(5, 5, 5);
        ack_mode = 1;
        exp_q.push_back(3'b100);
        do_start(20);
        wait_sig("post_rst_done", 0, 100, n);
        check("post_rst_inv_hi", inv_hi, 4);
        check("post_rst_remaining", remaining, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispense_controller.md
Name: change_dispense_controller

Overview:
- Sequences the coin hopper that returns change after a purchase or cancel.
- The main FSM issues one start pulse with the amount owed. This block then ejects coins one at a time, largest denomination first, and confirms each coin on the hopper drop sensor.
- It keeps the per-denomination coin inventory and reports completion, jams and short-change faults.

Parameters:
- AMT_W, 10, width of money amounts (units of smallest denomination value)
- CNT_W, 8, width of each inventory counter
- DEN_HI, 20, high coin value
- DEN_MID, 10, mid coin value
- DEN_LO, 5, low coin value
- PULSE_CYC, 4, eject solenoid pulse width in clk cycles (≥1)
- ACK_TIMEOUT, 1000, cycles to wait for drop sensor after pulse ends

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- change_amount  in  AMT_W  amount owed; latched with start
- load_inv  in  1  load inventory; honoured only in IDLE or FAULT
- inv_hi_in / inv_mid_in / inv_lo_in  in  CNT_W each  refill counts
- clear  in  1  leaves FAULT
- hopper_ack  in  1  coin-dropped sensor, synchronous, ≥1 cycle high per coin
- eject  out  3  one-hot solenoid drive {hi,mid,lo}
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, change fully paid
- error  out  1  high while in FAULT
- err_code  out  2  00 none, 01 short (no coin fits), 10 jam (ack timeout)
- remaining  out  AMT_W  amount still owed
- inv_hi / inv_mid / inv_lo  out  CNT_W each  current inventory

Behaviour:
- Reset (async, rst=1) forces the following immediately; no coin is counted:
  - state IDLE
  - eject=000, busy=0, done=0, error=0, err_code=00, remaining=0
  - all inventories 0
- States: IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT.
- IDLE:
  - start=1 latches change_amount into remaining and goes to SELECT next cycle.
  - load_inv=1 copies the three refill counts.
  - start and load_inv together: load takes effect first, so SELECT sees the new counts.
- SELECT (one cycle):
  - remaining==0 → DONE.
  - Otherwise pick the first denomination in order HI, MID, LO with value ≤ remaining and inventory>0; latch it and go to EJECT.
  - No candidate → FAULT, err_code=01; remaining holds the shortfall.
- EJECT:
  - eject bit of the chosen coin held high for exactly PULSE_CYC cycles, then WAIT_ACK.
  - Pulse counter resets on every entry.
- WAIT_ACK:
  - eject=000; cycle counter runs from 0.
  - hopper_ack=1 → subtract the denomination from remaining, decrement that inventory, go to SELECT.
  - Counter reaches ACK_TIMEOUT without ack → FAULT, err_code=10; remaining and inventory are not changed.
- An ack seen during EJECT is registered as a pending flag. WAIT_ACK then completes on its first cycle.
- One coin is credited per EJECT/WAIT_ACK pass. Extra acks within the same pass are ignored.
- Acks in IDLE, SELECT, DONE or FAULT are ignored.
- Arithmetic: subtraction never underflows, because the selection guarantees value ≤ remaining. Inventory never decrements below 0.
- DONE: done=1 for one cycle, then IDLE. remaining reads 0.
- FAULT:
  - error=1 and busy=1; eject=000.
  - clear=1 → IDLE next cycle, err_code=00, remaining=0.
  - load_inv is allowed in FAULT; start is ignored.
- start while busy is ignored; there is no queueing.
- Latency for the first coin: start at cycle T gives SELECT at T+1 and eject high over T+2 … T+1+PULSE_CYC.
- Zero amount: done pulses at T+2.
- Any remaining not a multiple of DEN_LO ends in FAULT/short with that residue left in remaining.

Test Plan:
- Normal path (inv 5/5/5, start with 35, ack 2 cycles after each pulse):
  - eject sequence 100, 010, 001, each 4 cycles wide.
  - done pulses once; remaining=0; inventory 4/4/4; error=0.
- Substitution (inv 1/5/5, amount 40):
  - ejects hi, mid, mid; done; inventory 0/3/5.
- Short change (inv 0/0/1, amount 15):
  - one lo coin; then FAULT, err_code=01, remaining=10.
  - clear → IDLE, error=0.
- Jam (inv 5/5/5, amount 10, no ack):
  - error rises exactly PULSE_CYC+ACK_TIMEOUT+2 cycles after start; err_code=10; inv_mid stays 5; remaining=10.
- Edge cases:
  - amount 0 → done at T+2, eject never asserted.
  - start during busy is ignored.
  - ack asserted during the EJECT pulse is credited once.
  - ack held high for 5 cycles credits one coin.
- Reset mid-EJECT:
  - eject drops to 000 in the same cycle without waiting for clk; all outputs take their reset values.
  - The next start works normally after inventory is reloaded.
